// File: rtl/arb_pkg.sv
// Shared constants for the four-way round-robin arbiter and its active-low decoder.
package arb_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

    localparam logic [3:0] NO_GRANT = 4'b1111;

    localparam int unsigned MAX_HOLD_DEFAULT = 8;

    // Result of a round-robin search: whether any request was found, and which one.
    typedef struct packed {
        logic       vld;
        logic [1:0] idx;
    } pick_t;

endpackage

// File: rtl/decoder2to4_n.sv
// 2-to-4 decoder with active-low enable and active-low one-hot output.
module decoder2to4_n
    import arb_pkg::*;
(
    input  logic [1:0] idx_i,
    input  logic       enable_n_i,
    output logic [3:0] dec_n_o
);

    always_comb begin
        dec_n_o = NO_GRANT;
        if (!enable_n_i) begin
            dec_n_o[idx_i] = 1'b0;
        end
    end

endmodule

// File: rtl/rr_arbiter4_dl.sv
// Four-requester round-robin arbiter with hold limit and active-low one-hot grant.
// Optional grant lock (suppresses forced rotation) is built when ARB_LOCK_EN is defined.
module rr_arbiter4_dl
    import arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = MAX_HOLD_DEFAULT,
    parameter int unsigned CNT_W    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en_n,
    input  logic [3:0] req,
    input  logic       lock,
    output logic [3:0] gnt_n,
    output logic [1:0] gnt_idx,
    output logic       gnt_vld
);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    // First set bit of r, searching from after+1 and wrapping back round to after itself.
    function automatic pick_t pick_next(input logic [3:0] r, input logic [1:0] after);
        pick_t      p;
        logic [1:0] c;
        p.vld = 1'b0;
        p.idx = after;
        for (int k = 1; k <= 4; k++) begin
            c = after + 2'(k);
            if (!p.vld && r[c]) begin
                p.vld = 1'b1;
                p.idx = c;
            end
        end
        return p;
    endfunction

    state_e           state_q, state_d;
    logic             gnt_vld_q, gnt_vld_d;
    logic [1:0]       gnt_idx_q, gnt_idx_d;
    logic [1:0]       last_idx_q, last_idx_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [3:0]       gnt_n_q, gnt_n_d;

    logic [3:0] others;
    pick_t      pick_all;
    pick_t      pick_oth;
    logic       rotate_ok;

`ifdef ARB_LOCK_EN
    assign rotate_ok = ~lock;
`else
    logic unused_lock;
    assign unused_lock = lock;
    assign rotate_ok   = 1'b1;
`endif

    always_comb begin
        others   = req & ~(4'b0001 << gnt_idx_q);
        pick_all = pick_next(req, last_idx_q);
        pick_oth = pick_next(others, gnt_idx_q);

        state_d    = state_q;
        gnt_vld_d  = gnt_vld_q;
        gnt_idx_d  = gnt_idx_q;
        last_idx_d = last_idx_q;
        hold_cnt_d = hold_cnt_q;

        unique case (state_q)
            ST_IDLE: begin
                if (!en_n && pick_all.vld) begin
                    state_d    = ST_GRANT;
                    gnt_vld_d  = 1'b1;
                    gnt_idx_d  = pick_all.idx;
                    last_idx_d = pick_all.idx;
                    hold_cnt_d = '0;
                end
            end
            ST_GRANT: begin
                if (en_n) begin
                    state_d    = ST_IDLE;
                    gnt_vld_d  = 1'b0;
                    hold_cnt_d = '0;
                end else if (!req[gnt_idx_q]) begin
                    // Holder released: hand off in the same edge, released one goes last.
                    if (pick_oth.vld) begin
                        gnt_idx_d  = pick_oth.idx;
                        last_idx_d = pick_oth.idx;
                        hold_cnt_d = '0;
                    end else begin
                        state_d    = ST_IDLE;
                        gnt_vld_d  = 1'b0;
                        hold_cnt_d = '0;
                    end
                end else if (hold_cnt_q == HOLD_LAST && pick_oth.vld && rotate_ok) begin
                    gnt_idx_d  = pick_oth.idx;
                    last_idx_d = pick_oth.idx;
                    hold_cnt_d = '0;
                end else if (hold_cnt_q != HOLD_LAST) begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                gnt_vld_d  = 1'b0;
                hold_cnt_d = '0;
            end
        endcase
    end

    decoder2to4_n u_dec (
        .idx_i      (gnt_idx_d),
        .enable_n_i (~gnt_vld_d),
        .dec_n_o    (gnt_n_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            gnt_vld_q  <= 1'b0;
            gnt_idx_q  <= 2'b00;
            last_idx_q <= 2'b11;
            hold_cnt_q <= '0;
            gnt_n_q    <= NO_GRANT;
        end else begin
            state_q    <= state_d;
            gnt_vld_q  <= gnt_vld_d;
            gnt_idx_q  <= gnt_idx_d;
            last_idx_q <= last_idx_d;
            hold_cnt_q <= hold_cnt_d;
            gnt_n_q    <= gnt_n_d;
        end
    end

    assign gnt_n   = gnt_n_q;
    assign gnt_idx = gnt_idx_q;
    assign gnt_vld = gnt_vld_q;

endmodule

// File: tb/tb_rr_arbiter4_dl.sv
// Self-checking bench for rr_arbiter4_dl: vector table, directed corner sequences, and
// randomized traffic against a cycle-count based reference model.
module tb_rr_arbiter4_dl;

    localparam int MAX_HOLD = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en_n = 1'b1;
    logic [3:0] req = 4'b0000;
    logic       lock = 1'b0;
    logic [3:0] gnt_n;
    logic [1:0] gnt_idx;
    logic       gnt_vld;

    int n_checks = 0;
    int n_fail   = 0;

    rr_arbiter4_dl #(
        .MAX_HOLD (MAX_HOLD),
        .CNT_W    (4)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_n    (en_n),
        .req     (req),
        .lock    (lock),
        .gnt_n   (gnt_n),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld)
    );

    always #5 clk = ~clk;

    // Reference model: who holds the grant, whose turn search starts after, and how
    // many consecutive cycles the holder has had the grant.
    int m_holder;
    int m_ptr;
    int m_streak;

    function automatic int first_after(input logic [3:0] r, input int from);
        for (int k = 1; k <= 4; k++) begin
            if (r[(from + k) % 4]) return (from + k) % 4;
        end
        return -1;
    endfunction

    function automatic void model_reset();
        m_holder = -1;
        m_ptr    = 3;
        m_streak = 0;
    endfunction

    function automatic void model_step(input logic [3:0] r, input logic e_n, input logic lk);
        logic [3:0] oth;
        logic       lock_active;
        int         w;
`ifdef ARB_LOCK_EN
        lock_active = lk;
`else
        lock_active = 1'b0 & lk;
`endif
        if (e_n) begin
            m_holder = -1;
        end else if (m_holder < 0 || !r[m_holder]) begin
            w = first_after(r, m_ptr);
            m_holder = w;
            if (w >= 0) begin
                m_ptr    = w;
                m_streak = 1;
            end
        end else begin
            oth = r;
            oth[m_holder] = 1'b0;
            if (m_streak >= MAX_HOLD && oth != 4'b0000 && !lock_active) begin
                w = first_after(oth, m_holder);
                m_holder = w;
                m_ptr    = w;
                m_streak = 1;
            end else begin
                m_streak++;
            end
        end
    endfunction

    function automatic logic [3:0] onehot_n(input logic v, input logic [1:0] i);
        logic [3:0] one;
        one = 4'b0001;
        return v ? ~(one << i) : 4'b1111;
    endfunction

    task automatic check(input string name, input logic ev, input logic [1:0] ei,
                         input logic [3:0] en);
        n_checks++;
        if (gnt_vld !== ev) begin
            n_fail++;
            $display("FAIL %s gnt_vld: got %b expected %b at %0t", name, gnt_vld, ev, $time);
        end
        n_checks++;
        if (gnt_n !== en) begin
            n_fail++;
            $display("FAIL %s gnt_n: got %b expected %b at %0t", name, gnt_n, en, $time);
        end
        if (ev) begin
            n_checks++;
            if (gnt_idx !== ei) begin
                n_fail++;
                $display("FAIL %s gnt_idx: got %0d expected %0d at %0t", name, gnt_idx, ei,
                         $time);
            end
        end
    endtask

    task automatic check_model(input string name);
        logic v;
        logic [1:0] i;
        v = (m_holder >= 0);
        i = v ? 2'(m_holder) : 2'd0;
        check(name, v, i, onehot_n(v, i));
    endtask

    // Apply inputs for one edge; called 1 time unit after an edge, samples 1 after the next.
    task automatic cycle(input logic [3:0] r, input logic e_n, input logic lk);
        req  = r;
        en_n = e_n;
        lock = lk;
        model_step(r, e_n, lk);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        req   = 4'b0000;
        en_n  = 1'b1;
        lock  = 1'b0;
        rst_n = 1'b0;
        model_reset();
        #2;
        n_checks++;
        if (gnt_idx !== 2'b00) begin
            n_fail++;
            $display("FAIL reset gnt_idx: got %0d expected 0", gnt_idx);
        end
        check("reset", 1'b0, 2'd0, 4'b1111);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [3:0] req;
        logic       en_n;
        logic       lock;
        logic       exp_vld;
        logic [1:0] exp_idx;
        logic [3:0] exp_n;
    } vec_t;

    vec_t vecs[11];

    initial begin
        logic [3:0] r;
        logic       e;
        logic       lk;
        logic [1:0] ei;

        // Handoff ring, enable drop with preserved pointer, then release to idle.
        vecs[0]  = '{4'b1111, 1'b0, 1'b0, 1'b1, 2'd0, 4'b1110};
        vecs[1]  = '{4'b1110, 1'b0, 1'b0, 1'b1, 2'd1, 4'b1101};
        vecs[2]  = '{4'b1101, 1'b0, 1'b0, 1'b1, 2'd2, 4'b1011};
        vecs[3]  = '{4'b1011, 1'b0, 1'b0, 1'b1, 2'd3, 4'b0111};
        vecs[4]  = '{4'b0111, 1'b0, 1'b0, 1'b1, 2'd0, 4'b1110};
        vecs[5]  = '{4'b0111, 1'b1, 1'b0, 1'b0, 2'd0, 4'b1111};
        vecs[6]  = '{4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 4'b1111};
        vecs[7]  = '{4'b0010, 1'b0, 1'b0, 1'b1, 2'd1, 4'b1101};
        vecs[8]  = '{4'b0010, 1'b1, 1'b0, 1'b0, 2'd0, 4'b1111};
        vecs[9]  = '{4'b0011, 1'b0, 1'b0, 1'b1, 2'd0, 4'b1110};
        vecs[10] = '{4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 4'b1111};

        model_reset();
        #3;
        do_reset();

        // First grant, then asynchronous reset between edges.
        cycle(4'b0001, 1'b0, 1'b0);
        check("first_grant", 1'b1, 2'd0, 4'b1110);
        #3;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (gnt_n !== 4'b1111) begin
            n_fail++;
            $display("FAIL async_reset gnt_n: got %b expected 1111", gnt_n);
        end
        do_reset();

        foreach (vecs[k]) begin
            cycle(vecs[k].req, vecs[k].en_n, vecs[k].lock);
            check($sformatf("vec%0d", k), vecs[k].exp_vld, vecs[k].exp_idx, vecs[k].exp_n);
        end

        // Two continuous requesters alternate every MAX_HOLD cycles.
        do_reset();
        for (int c = 0; c < 3 * MAX_HOLD; c++) begin
            cycle(4'b0101, 1'b0, 1'b0);
            ei = ((c / MAX_HOLD) % 2 == 1) ? 2'd2 : 2'd0;
            check($sformatf("rotate_c%0d", c), 1'b1, ei, onehot_n(1'b1, ei));
        end

        // A lone requester keeps the grant well past the hold limit.
        do_reset();
        for (int c = 0; c < MAX_HOLD + 5; c++) begin
            cycle(4'b0001, 1'b0, 1'b0);
            check($sformatf("alone_c%0d", c), 1'b1, 2'd0, 4'b1110);
        end
        // A newcomer after saturation takes over at the very next edge.
        cycle(4'b0011, 1'b0, 1'b0);
        check("late_rival", 1'b1, 2'd1, 4'b1101);

        // Lock holds requester 0 for 20 cycles when built in; otherwise rotation continues.
        do_reset();
        for (int c = 0; c < 21; c++) begin
            lk = (c < 20);
            cycle(4'b0011, 1'b0, lk);
`ifdef ARB_LOCK_EN
            ei = (c < 20) ? 2'd0 : 2'd1;
`else
            ei = ((c / MAX_HOLD) % 2 == 1) ? 2'd1 : 2'd0;
`endif
            check($sformatf("lock_c%0d", c), 1'b1, ei, onehot_n(1'b1, ei));
        end

        // Enabled but nobody asking: stays idle.
        do_reset();
        for (int c = 0; c < 10; c++) begin
            cycle(4'b0000, 1'b0, 1'b0);
            check($sformatf("idle_c%0d", c), 1'b0, 2'd0, 4'b1111);
        end

        // Randomized traffic against the model; requests change slowly so holds build up.
        r = 4'b0000;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(3) == 0) r = 4'($urandom_range(15));
            e  = ($urandom_range(19) == 0);
            lk = ($urandom_range(3) == 0);
            cycle(r, e, lk);
            check_model($sformatf("rand_c%0d", c));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rr_arbiter4_dl.md
Name: rr_arbiter4_dl

Overview:
- Four-requester round-robin arbiter for a shared resource. It selects one requester and drives its select line through a 2-to-4 active-low decoder.
- Outputs are an active-low one-hot grant, matching the team's active-low decoder convention, plus the 2-bit encoded index.
- Sits between requesting agents and the decoder-selected resource (bus, memory bank, display digit).

Parameters:
- MAX_HOLD, 8, maximum consecutive cycles one requester keeps the grant while others are waiting. Legal range 1..15.
- CNT_W, 4, width of the hold counter. Must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- en_n  input  1  active-low arbiter enable; 1 forces no grant.
- req  input  4  request vector, active-high, bit i = requester i.
- lock  input  1  grant-extension request (used only with ARB_LOCK_EN).
- gnt_n  output  4  active-low one-hot grant; 4'b1111 = no grant.
- gnt_idx  output  2  index of the current grant; valid only when gnt_vld=1.
- gnt_vld  output  1  a grant is active.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, gnt_vld=0, gnt_n=4'b1111, gnt_idx=2'b00, hold_cnt=0.
  - Round-robin pointer last_idx=2'b11, so requester 0 wins first.
- All outputs are registered. A request seen at edge t is granted at edge t (visible in cycle t+1). Latency is one clock.
- Selection: search req starting from (last_idx+1) mod 4 and wrapping; the first set bit wins.
- State IDLE:
  - If en_n=0 and req!=0: select the winner, go to GRANT, load gnt_idx, set last_idx=winner, hold_cnt=0.
  - Otherwise stay in IDLE with outputs idle.
- State GRANT, checked at each edge in this priority order:
  - (1) en_n=1: go to IDLE, gnt_n=4'b1111, gnt_vld=0. last_idx is preserved.
  - (2) req[gnt_idx]=0: re-arbitrate among the remaining requests in the same edge (back-to-back handoff, no idle cycle). If none remain, go to IDLE.
  - (3) hold_cnt==MAX_HOLD-1 and another req bit is set: forced rotation to the next winner after gnt_idx, hold_cnt=0.
  - (4) Otherwise keep the grant. hold_cnt increments and saturates at MAX_HOLD-1. It does not wrap while the requester is alone.
- Each new grant, including a handoff, resets hold_cnt=0 and updates last_idx.
- gnt_n is always the decoder output: gnt_n[i]=0 exactly when gnt_vld=1 and gnt_idx=i. At most one bit is ever low.
- Simultaneous release and new requests: the released requester becomes lowest priority and the search starts at gnt_idx+1.
- A requester that deasserts and reasserts in the same cycle it is granted is treated as still holding.
- Reset asserted mid-grant releases immediately and asynchronously: gnt_n=4'b1111 without waiting for a clock.

Optional Feature:
- Macro: ARB_LOCK_EN.
- When defined:
  - lock=1 while in GRANT suppresses forced rotation (rule 3), so the holder keeps the grant beyond MAX_HOLD until req[gnt_idx] drops or en_n=1.
  - hold_cnt still saturates.
- When undefined:
  - The lock port remains on the interface but is ignored.
  - Rotation is always enforced.

Decomposition:
- Shared package arb_pkg holds:
  - state encoding constants ST_IDLE=1'b0, ST_GRANT=1'b1;
  - the NO_GRANT=4'b1111 constant;
  - default MAX_HOLD.
- One sub-module, decoder2to4_n: combinational 2-bit index plus active-low enable in, active-low one-hot out.
  - Instantiated with enable_n = ~gnt_vld_next; its output is registered into gnt_n.
- Next-winner priority search is a function inside rr_arbiter4_dl.

Test Plan:
- Reset, then req=4'b0001, en_n=0: after one edge gnt_n=4'b1110, gnt_idx=0, gnt_vld=1. Assert rst_n=0 mid-grant: gnt_n=4'b1111 immediately.
- req=4'b1111 held, each requester dropping after one granted cycle: grants go 0,1,2,3,0 in consecutive cycles with no idle gap.
- req=4'b0101 held continuously, MAX_HOLD=8: grant 0 for 8 cycles, then 2 for 8 cycles, then 0. Alone on req=4'b0001: grant held more than 8 cycles, hold_cnt saturated at 7.
- Grant on requester 1, en_n goes 1: gnt_n=4'b1111 the next cycle. en_n back to 0 with req=4'b0011: grant goes to 0, not 1, because the pointer was preserved at 1.
- With ARB_LOCK_EN, req=4'b0011, lock=1: requester 0 holds 20 cycles. lock drops: rotation to 1 at the next edge because hold_cnt is already saturated. Without the macro, rotation occurs at cycle 8.
- en_n=0, req=0 for 10 cycles: gnt_vld=0, gnt_n=4'b1111 throughout, state stays IDLE.
